// File: rtl/instruction_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch front end.
package instruction_fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // Instructions are word aligned, so the two low address bits carry no information.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives a synchronous instruction memory and presents
// fetched words to a consumer that can stall, with a one-entry skid buffer.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0004
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_word,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_STREAM,
        ST_HOLD
    } fetch_state_e;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_v_q, pend_v_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            hold_v_q, hold_v_d;
    logic [ILEN-1:0] hold_word_q, hold_word_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;

    fetch_state_e state;

    // NOTE: the buffer data registers are reset too, so instr/instr_pc are
    // defined zeros out of reset rather than X until the first stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            pend_v_q    <= 1'b0;
            pend_pc_q   <= '0;
            hold_v_q    <= 1'b0;
            hold_word_q <= '0;
            hold_pc_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            pend_v_q    <= pend_v_d;
            pend_pc_q   <= pend_pc_d;
            hold_v_q    <= hold_v_d;
            hold_word_q <= hold_word_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    always_comb begin
        if (hold_v_q) begin
            state = ST_HOLD;
        end else if (pend_v_q) begin
            state = ST_STREAM;
        end else begin
            state = ST_EMPTY;
        end
    end

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path can infer a latch.
    always_comb begin
        pc_d        = pc_q;
        pend_v_d    = pend_v_q;
        pend_pc_d   = pend_pc_q;
        hold_v_d    = hold_v_q;
        hold_word_d = hold_word_q;
        hold_pc_d   = hold_pc_q;

        if (redirect_valid) begin
            pc_d     = align_pc(redirect_pc);
            pend_v_d = 1'b0;
            hold_v_d = 1'b0;
        end else if (!stall) begin
            pc_d      = pc_q + PC_STEP;
            pend_v_d  = 1'b1;
            pend_pc_d = pc_q;
            hold_v_d  = 1'b0;
        end else begin
            // The memory keeps reading pc_q while stalled, so a word still in
            // flight must be parked here or it would be overwritten.
            pend_v_d = 1'b0;
            if (state == ST_STREAM) begin
                hold_v_d    = 1'b1;
                hold_word_d = imem_word;
                hold_pc_d   = pend_pc_q;
            end
        end
    end

    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        case (state)
            ST_HOLD: begin
                instr_valid = 1'b1;
                instr       = hold_word_q;
                instr_pc    = hold_pc_q;
            end
            ST_STREAM: begin
                instr_valid = 1'b1;
                instr       = imem_word;
                instr_pc    = pend_pc_q;
            end
            default: begin
                instr_valid = 1'b0;
            end
        endcase
    end

    assign imem_addr = pc_q;

endmodule
